// File: rtl/pipe_stage_buf_if.sv
// rtl/pipe_stage_buf_if.sv - handshake and data bundle between pipe_stage_buf and its neighbours
//
// Purpose : groups the upstream handshake, downstream handshake, flush control and
//           status outputs of one pipe_stage_buf instance.
// Signals :
//   flush_i     discard all stored entries this cycle
//   in_valid_i  upstream bundle valid          in_ready_o  stage can accept
//   in_stat_i   upstream stat (4b)             in_icode_i  upstream icode (4b)
//   in_val_i    NVAL value words               in_dst_i    NDST register IDs
//   out_valid_o head entry valid               out_ready_i downstream consumes head
//   out_stat_o  head stat                      out_icode_o head icode
//   out_val_o   head value words               out_dst_o   head register IDs
//   count_o     occupied entries               halted_o    exception halt latched
// Modports: slave = the stage itself, master = the surrounding pipeline / testbench.

interface pipe_stage_buf_if #(
   parameter int WORD_W = 64,
   parameter int NVAL   = 2,
   parameter int NDST   = 2
) ();
   logic                     flush_i;
   logic                     in_valid_i;
   logic                     in_ready_o;
   logic [3:0]               in_stat_i;
   logic [3:0]               in_icode_i;
   logic [NVAL*WORD_W-1:0]   in_val_i;
   logic [NDST*4-1:0]        in_dst_i;
   logic                     out_valid_o;
   logic                     out_ready_i;
   logic [3:0]               out_stat_o;
   logic [3:0]               out_icode_o;
   logic [NVAL*WORD_W-1:0]   out_val_o;
   logic [NDST*4-1:0]        out_dst_o;
   logic [1:0]               count_o;
   logic                     halted_o;

   modport slave (
      input  flush_i, in_valid_i, in_stat_i, in_icode_i, in_val_i, in_dst_i, out_ready_i,
      output in_ready_o, out_valid_o, out_stat_o, out_icode_o, out_val_o, out_dst_o,
             count_o, halted_o
   );

   modport master (
      output flush_i, in_valid_i, in_stat_i, in_icode_i, in_val_i, in_dst_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_stat_o, out_icode_o, out_val_o, out_dst_o,
             count_o, halted_o
   );
endinterface

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - valid/ready Y86 pipeline stage register with optional skid entry
//
// Purpose : holds one generic stage bundle (stat, icode, NVAL value words, NDST register
//           IDs) between two pipeline stages. DEPTH=1 behaves as a classic pipeline
//           register, DEPTH=2 adds a skid entry so in_ready_o does not depend on
//           out_ready_i. Supports flush-to-bubble and a sticky exception halt.
// Ports   :
//   clk_i   rising-edge clock
//   rstn_i  asynchronous active-low reset
//   bus     pipe_stage_buf_if.slave (handshakes, data, flush, count, halt status)

module pipe_stage_buf #(
   parameter int         WORD_W    = 64,
   parameter int         NVAL      = 2,
   parameter int         NDST      = 2,
   parameter int         DEPTH     = 2,
   parameter logic [3:0] BUB_STAT  = 4'h1,
   parameter logic [3:0] BUB_ICODE = 4'h1,
   parameter logic [3:0] BUB_DST   = 4'hF
) (
   input logic             clk_i,
   input logic             rstn_i,
   pipe_stage_buf_if.slave bus
);
   localparam int         VW       = NVAL * WORD_W;
   localparam int         DW       = NDST * 4;
   localparam logic [3:0] STAT_AOK = 4'h1;

   generate
      if (DEPTH != 1 && DEPTH != 2) begin : g_bad_depth
         $error("pipe_stage_buf: DEPTH must be 1 or 2");
      end
   endgenerate

   // Entry 0 is the head presented downstream; entry 1 is the skid (DEPTH=2 only).
   logic [3:0]    r_stat  [2];
   logic [3:0]    r_icode [2];
   logic [VW-1:0] r_val   [2];
   logic [DW-1:0] r_dst   [2];
   logic [1:0]    r_count;
   logic          r_halted;

   logic          w_out_valid;
   logic          w_in_ready;
   logic          w_consume;
   logic          w_accept;
   logic          w_shift;
   logic          w_wr_idx;
   logic [1:0]    w_count_nxt;

   assign w_out_valid = (r_count != 2'd0);

   generate
      if (DEPTH == 1) begin : g_ready_d1
         // Single entry: a consume on this edge frees the slot for the incoming bundle.
         assign w_in_ready = ~r_halted & (~w_out_valid | bus.out_ready_i);
      end else begin : g_ready_d2
         // Skid buffer: ready depends only on stored state, breaking the ready chain.
         assign w_in_ready = ~r_halted & (r_count != 2'd2);
      end
   endgenerate

   assign w_consume   = w_out_valid & bus.out_ready_i;
   assign w_accept    = bus.in_valid_i & w_in_ready & ~bus.flush_i;
   assign w_shift     = w_consume & (r_count == 2'd2);
   assign w_count_nxt = r_count + {1'b0, w_accept} - {1'b0, w_consume};

   // New data lands in the first slot that is free after this edge's consume,
   // i.e. index (count - consume).
   assign w_wr_idx = (r_count == 2'd2) | ((r_count == 2'd1) & ~w_consume);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_count  <= 2'd0;
         r_halted <= 1'b0;
         for (int k = 0; k < 2; k++) begin
            r_stat[k]  <= BUB_STAT;
            r_icode[k] <= BUB_ICODE;
            r_val[k]   <= '0;
            r_dst[k]   <= {NDST{BUB_DST}};
         end
      end else begin
         if (bus.flush_i) begin
            // A same-edge consume has already been seen downstream; only storage is dropped.
            r_count  <= 2'd0;
            r_halted <= 1'b0;
         end else begin
            r_count <= w_count_nxt;
            if (w_consume && (r_stat[0] != STAT_AOK)) begin
               r_halted <= 1'b1;
            end
         end

         if (w_shift) begin
            r_stat[0]  <= r_stat[1];
            r_icode[0] <= r_icode[1];
            r_val[0]   <= r_val[1];
            r_dst[0]   <= r_dst[1];
         end

         if (w_accept) begin
            r_stat[w_wr_idx]  <= bus.in_stat_i;
            r_icode[w_wr_idx] <= bus.in_icode_i;
            r_val[w_wr_idx]   <= bus.in_val_i;
            r_dst[w_wr_idx]   <= bus.in_dst_i;
         end
      end
   end

   // Empty stage presents a bubble rather than whatever stale data sits in entry 0.
   assign bus.in_ready_o  = w_in_ready;
   assign bus.out_valid_o = w_out_valid;
   assign bus.out_stat_o  = w_out_valid ? r_stat[0]  : BUB_STAT;
   assign bus.out_icode_o = w_out_valid ? r_icode[0] : BUB_ICODE;
   assign bus.out_val_o   = w_out_valid ? r_val[0]   : '0;
   assign bus.out_dst_o   = w_out_valid ? r_dst[0]   : {NDST{BUB_DST}};
   assign bus.count_o     = r_count;
   assign bus.halted_o    = r_halted;
endmodule
